// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS            = 8;
    localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 104;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LATCH,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port plus serial-side status, seen from the transmitter (master) or its environment.
interface fifo_uart_tx_if;
    import uart_pkg::*;

    logic                      enable;
    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_data;
    logic                      fifo_rd_en;
    logic                      tx;
    logic                      busy;
    logic                      tx_done;

    modport master (
        input  enable,
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en,
        output tx,
        output busy,
        output tx_done
    );

    modport slave (
        output enable,
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en,
        input  tx,
        input  busy,
        input  tx_done
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, ticks on terminal count, clears on request.
module uart_baud_tick import uart_pkg::*; #(
    parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO one byte at a time and sends each byte as an 8N1 frame, LSB first.
module fifo_uart_tx import uart_pkg::*; #(
    parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_uart_tx_if.master    bus_io
);

    localparam int unsigned IdxW = $clog2(UART_DATA_BITS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(UART_DATA_BITS - 1);

    tx_state_t                 state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [IdxW-1:0]           bit_idx_q, bit_idx_d;
    logic                      tick;

    // Every state change restarts the bit period so each phase gets a full CLKS_PER_BIT.
    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (state_d != state_q),
        .tick_o  (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        unique case (state_q)
            IDLE: begin
                if (bus_io.enable && !bus_io.fifo_empty) state_d = POP;
            end
            POP: state_d = LATCH;
            LATCH: begin
                shift_d = bus_io.fifo_data;
                state_d = START;
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == LastIdx) state_d = STOP;
                end
            end
            STOP: begin
                if (tick) state_d = (bus_io.enable && !bus_io.fifo_empty) ? POP : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    // Outputs decode registered state only, so reset forces the line high at once.
    assign bus_io.fifo_rd_en = (state_q == POP);
    assign bus_io.busy       = (state_q != IDLE);
    assign bus_io.tx_done    = (state_q == STOP) && tick;
    assign bus_io.tx         = (state_q == START) ? 1'b0 :
                               (state_q == DATA)  ? shift_q[0] : 1'b1;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFO, line receiver model and a byte scoreboard.
module tb_fifo_uart_tx;

    localparam int CPB         = 4;
    localparam int FrameCycles = 10 * CPB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fifo_uart_tx_if bus ();

    fifo_uart_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    // FIFO model: data appears the cycle after a pop.
    logic [7:0] mem [256];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;

    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_data <= mem[rd_ptr];
            rd_ptr        <= rd_ptr + 8'd1;
        end
    end

    always @(negedge clk) bus.fifo_empty <= (wr_ptr == rd_ptr);

    // Line monitor and receiver model.
    int         cyc        = 0;
    int         rd_pulses  = 0;
    int         rd_last    = 0;
    int         rd_prev    = 0;
    int         rd_double  = 0;
    logic       prev_rd    = 1'b0;
    int         done_cyc   = 0;
    int         tx_low     = 0;
    logic       active     = 1'b0;
    int         fcyc       = 0;
    int         start_cyc  = 0;
    logic       cur_lv     = 1'b1;
    logic [9:0] lv_vec     = '0;
    int         frame_err  = 0;
    int         last_end   = 0;
    int         last_gap   = 0;
    logic [7:0] rx_q[$];
    logic [9:0] lv_q[$];
    int         start_q[$];

    always @(negedge clk) begin
        cyc     <= cyc + 1;
        prev_rd <= bus.fifo_rd_en;
        if (bus.fifo_rd_en) begin
            rd_pulses <= rd_pulses + 1;
            rd_prev   <= rd_last;
            rd_last   <= cyc;
            if (prev_rd) rd_double <= rd_double + 1;
        end
        if (bus.tx_done) done_cyc <= cyc;
        if (bus.tx !== 1'b1) tx_low <= tx_low + 1;
        if (!rst_n) begin
            active <= 1'b0;
        end else if (!active) begin
            if (bus.tx === 1'b0) begin
                active    <= 1'b1;
                fcyc      <= 1;
                start_cyc <= cyc;
                cur_lv    <= 1'b0;
                lv_vec    <= '0;
                last_gap  <= cyc - last_end - 1;
            end
        end else begin
            fcyc <= fcyc + 1;
            if (fcyc % CPB == 0) begin
                lv_vec[4'(fcyc / CPB)] <= bus.tx;
                cur_lv                 <= bus.tx;
            end else if (bus.tx !== cur_lv) begin
                frame_err <= frame_err + 1;
            end
            if (fcyc == FrameCycles - 1) begin
                active   <= 1'b0;
                last_end <= cyc;
                rx_q.push_back(lv_vec[8:1]);
                lv_q.push_back(lv_vec);
                start_q.push_back(start_cyc);
            end
        end
    end

    int rx_rd = 0;

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr      = wr_ptr + 8'd1;
        exp_q.push_back(b);
    endtask

    task automatic wait_rx(input int need, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (rx_q.size() >= need) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int viol = 0;
        bit ok;
        logic [7:0] e;
        rst_n      = 1'b0;
        bus.enable = 1'b1;
        @(posedge clk);
        #1;
        push_byte(8'h5A);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.fifo_rd_en !== 1'b0) viol++;
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL reset_hold: violating cycles=%0d expected 0", viol);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.fifo_rd_en !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_pop: rd_en=%b expected 1", bus.fifo_rd_en);
        end
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_busy_pop: busy=%b expected 1", bus.busy);
        end
        wait_rx(rx_rd + 1, 200, ok);
        e = exp_q.pop_front();
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL reset_frame: no frame seen, expected byte %02h", e);
        end else begin
            total++;
            if (rx_q[rx_rd] !== e) begin
                bad++;
                $display("FAIL reset_byte: got %02h expected %02h", rx_q[rx_rd], e);
            end
            rx_rd++;
        end
    endtask

    task automatic test_single();
        int r0, f0;
        bit ok;
        logic [7:0] e;
        logic [9:0] lv_exp;
        @(posedge clk);
        #1;
        r0 = rd_pulses;
        f0 = frame_err;
        push_byte(8'hA5);
        wait_rx(rx_rd + 1, 300, ok);
        e      = exp_q.pop_front();
        lv_exp = {1'b1, e, 1'b0};
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL single_frame: no frame seen, expected byte %02h", e);
            return;
        end
        total++;
        if (rd_pulses - r0 != 1) begin
            bad++;
            $display("FAIL single_pops: got %0d pops expected 1", rd_pulses - r0);
        end
        total++;
        if (start_q[rx_rd] - rd_last != 2) begin
            bad++;
            $display("FAIL single_latency: start-pop=%0d expected 2", start_q[rx_rd] - rd_last);
        end
        total++;
        if (lv_q[rx_rd] !== lv_exp) begin
            bad++;
            $display("FAIL single_levels: got %b expected %b", lv_q[rx_rd], lv_exp);
        end
        total++;
        if (rx_q[rx_rd] !== e) begin
            bad++;
            $display("FAIL single_byte: got %02h expected %02h", rx_q[rx_rd], e);
        end
        total++;
        if (frame_err != f0) begin
            bad++;
            $display("FAIL single_hold: %0d level glitches expected 0", frame_err - f0);
        end
        total++;
        if (done_cyc != start_q[rx_rd] + FrameCycles - 1) begin
            bad++;
            $display("FAIL single_done: tx_done at frame cycle %0d expected %0d",
                     done_cyc - start_q[rx_rd] + 1, FrameCycles);
        end
        rx_rd++;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL single_busy_after: busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int r0;
        bit ok;
        logic [7:0] e;
        @(posedge clk);
        #1;
        r0 = rd_pulses;
        push_byte(8'h00);
        push_byte(8'hFF);
        wait_rx(rx_rd + 2, 400, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL b2b_frames: got %0d frames expected 2", rx_q.size() - rx_rd);
            return;
        end
        total++;
        if (rd_pulses - r0 != 2) begin
            bad++;
            $display("FAIL b2b_pops: got %0d pops expected 2", rd_pulses - r0);
        end
        total++;
        if (rd_last - rd_prev != FrameCycles + 2) begin
            bad++;
            $display("FAIL b2b_spacing: got %0d expected %0d", rd_last - rd_prev, FrameCycles + 2);
        end
        total++;
        if (last_gap != 2) begin
            bad++;
            $display("FAIL b2b_gap: idle-high cycles=%0d expected 2", last_gap);
        end
        total++;
        if (rd_double != 0) begin
            bad++;
            $display("FAIL b2b_double_pop: back-to-back pops=%0d expected 0", rd_double);
        end
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            total++;
            if (rx_q[rx_rd] !== e) begin
                bad++;
                $display("FAIL b2b_byte%0d: got %02h expected %02h", i, rx_q[rx_rd], e);
            end
            rx_rd++;
        end
    endtask

    task automatic test_empty();
        int r0, t0;
        @(posedge clk);
        #1;
        r0 = rd_pulses;
        t0 = tx_low;
        repeat (200) @(negedge clk);
        #1;
        total++;
        if (rd_pulses != r0) begin
            bad++;
            $display("FAIL empty_pop: got %0d pops expected 0", rd_pulses - r0);
        end
        total++;
        if (tx_low != t0) begin
            bad++;
            $display("FAIL empty_tx: tx low for %0d cycles expected 0", tx_low - t0);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL empty_busy: busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_enable_drop();
        int r0;
        bit ok;
        bit seen = 1'b0;
        logic [7:0] e;
        @(posedge clk);
        #1;
        r0 = rd_pulses;
        push_byte(8'h3C);
        push_byte(8'h99);
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = (rd_pulses > r0);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL drop_first_pop: pops=%0d expected 1", rd_pulses - r0);
        end
        repeat (10) @(posedge clk);
        #1;
        bus.enable = 1'b0;
        wait_rx(rx_rd + 1, 200, ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || rx_q[rx_rd] !== e) begin
            bad++;
            $display("FAIL drop_byte: got %02h (frame=%0b) expected %02h",
                     ok ? rx_q[rx_rd] : 8'hxx, ok, e);
        end
        if (ok) rx_rd++;
        repeat (60) @(negedge clk);
        #1;
        total++;
        if (rd_pulses - r0 != 1 || rx_q.size() != rx_rd) begin
            bad++;
            $display("FAIL drop_hold: pops=%0d frames=%0d expected 1 and 0",
                     rd_pulses - r0, rx_q.size() - rx_rd);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL drop_busy: busy=%b expected 0", bus.busy);
        end
        @(posedge clk);
        #1;
        bus.enable = 1'b1;
        wait_rx(rx_rd + 1, 200, ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || rx_q[rx_rd] !== e) begin
            bad++;
            $display("FAIL drop_resume: got %02h (frame=%0b) expected %02h",
                     ok ? rx_q[rx_rd] : 8'hxx, ok, e);
        end
        if (ok) rx_rd++;
        total++;
        if (rd_pulses - r0 != 2) begin
            bad++;
            $display("FAIL drop_pops: got %0d pops expected 2", rd_pulses - r0);
        end
    endtask

    task automatic test_mid_reset();
        int r0;
        bit ok;
        bit seen = 1'b0;
        logic pre_tx;
        logic [7:0] e;
        @(posedge clk);
        #1;
        r0 = rd_pulses;
        push_byte(8'h81);
        push_byte(8'h42);
        // Stop inside data bit 3 (frame cycles 16..19).
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = active && (fcyc == 18);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL mrst_reach_bit3: frame not reached, active=%b fcyc=%0d", active, fcyc);
        end
        @(posedge clk);
        #2;
        pre_tx = bus.tx;
        total++;
        if (pre_tx !== 1'b0) begin
            bad++;
            $display("FAIL mrst_bit3: tx=%b expected 0", pre_tx);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL mrst_async: tx=%b busy=%b expected 1 and 0", bus.tx, bus.busy);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        void'(exp_q.pop_front());
        wait_rx(rx_rd + 1, 300, ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || rx_q[rx_rd] !== e) begin
            bad++;
            $display("FAIL mrst_next_byte: got %02h (frame=%0b) expected %02h",
                     ok ? rx_q[rx_rd] : 8'hxx, ok, e);
        end
        if (ok) rx_rd++;
        total++;
        if (rd_pulses - r0 != 2) begin
            bad++;
            $display("FAIL mrst_pops: got %0d pops expected 2", rd_pulses - r0);
        end
        repeat (60) @(negedge clk);
        #1;
        total++;
        if (rx_q.size() != rx_rd || rd_pulses - r0 != 2) begin
            bad++;
            $display("FAIL mrst_no_resend: extra frames=%0d pops=%0d expected 0 and 2",
                     rx_q.size() - rx_rd, rd_pulses - r0);
        end
    endtask

    initial begin
        bus.enable = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_empty();
        test_enable_drop();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
